// File: rtl/rv32_pkg.sv
// Packet types shared between decode, issue and writeback.
package rv32_pkg;
  localparam int PKT_XLEN = 32;
  localparam int PKT_AW   = 5;

  typedef struct packed {
    logic [PKT_AW-1:0]   rs1_sel;
    logic [PKT_AW-1:0]   rs2_sel;
    logic [PKT_AW-1:0]   rd_sel;
    logic                rd_wen;
    logic [31:0]         imm32;
    logic [3:0]          alu_op;
    logic [31:0]         pc;
    logic                valid_opcode;
    logic                dont_forward;
  } rv32_instr_packet_t;

  typedef struct packed {
    logic                wb_enable;
    logic                valid_opcode;
    logic [PKT_AW-1:0]   wb_addr;
    logic [PKT_XLEN-1:0] wb_data;
  } rv32_mem2wb_packet_t;

  typedef struct packed {
    logic [PKT_XLEN-1:0] rs1_value;
    logic [PKT_XLEN-1:0] rs2_value;
    logic [PKT_AW-1:0]   rs1_sel;
    logic [PKT_AW-1:0]   rs2_sel;
    logic [PKT_AW-1:0]   rd_sel;
    logic                rd_wen;
    logic [31:0]         imm32;
    logic [3:0]          alu_op;
    logic [31:0]         pc;
    logic                valid_opcode;
    logic                dont_forward;
  } rv32_issue_packet_t;
endpackage

// File: rtl/regfile_mp.sv
// Multi-write-port register file: highest-indexed port wins, reads bypass same-cycle writes.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWB   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NWB-1:0]            wb_we,
  input  logic [NWB-1:0][AW-1:0]    wb_addr,
  input  logic [NWB-1:0][XLEN-1:0]  wb_data,
  input  logic [1:0][AW-1:0]        rd_addr,
  output logic [1:0][XLEN-1:0]      rd_data
);
  logic [NREGS-1:0][XLEN-1:0] regs;
  logic [NREGS-1:0][XLEN-1:0] wr_val;
  logic [NREGS-1:0]           wr_en;

  // Later ports overwrite earlier ones, giving the highest index priority.
  always_comb begin
    wr_en  = '0;
    wr_val = '0;
    for (int p = 0; p < NWB; p++) begin
      if (wb_we[p] && wb_addr[p] != '0) begin
        wr_en[wb_addr[p]]  = 1'b1;
        wr_val[wb_addr[p]] = wb_data[p];
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs <= '0;
    end else begin
      for (int r = 1; r < NREGS; r++) begin
        if (wr_en[r]) regs[r] <= wr_val[r];
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic [XLEN-1:0] val;
    always_comb begin
      val = (rd_addr[gi] == '0) ? '0 : regs[rd_addr[gi]];
      for (int p = 0; p < NWB; p++) begin
        if (wb_we[p] && wb_addr[p] == rd_addr[gi] && rd_addr[gi] != '0) val = wb_data[p];
      end
    end
    assign rd_data[gi] = val;
  end
endmodule

// File: rtl/regfile_issue_stage.sv
// Issue stage: operand read with writeback bypass, busy scoreboard, one-entry issue register.
module regfile_issue_stage
  import rv32_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NWB   = 2,
  localparam int AW   = $clog2(NREGS),
  localparam int CW   = $clog2(NWB + 1)
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                in_valid,
  output logic                in_ready,
  input  rv32_instr_packet_t  in_pkt,
  input  rv32_mem2wb_packet_t wb_pkt [NWB],
  output logic                out_valid,
  input  logic                out_ready,
  output rv32_issue_packet_t  out_pkt,
  input  logic                flush,
  output logic [CW-1:0]       commit_count,
  output logic [31:0]         stall_cycles
);
  logic [NWB-1:0]           wb_we;
  logic [NWB-1:0][AW-1:0]   wb_addr;
  logic [NWB-1:0][XLEN-1:0] wb_data;
  logic [1:0][AW-1:0]       rd_addr;
  logic [1:0][XLEN-1:0]     rd_data;
  logic [NREGS-1:0]         busy, busy_eff, clr_mask, set_mask, flush_mask;
  logic [AW-1:0]            rs1, rs2, rd, out_rd;
  logic                     hazard, accept;
  rv32_issue_packet_t       issue_next;

  for (genvar gi = 0; gi < NWB; gi++) begin : g_wb
    assign wb_addr[gi] = wb_pkt[gi].wb_addr[AW-1:0];
    assign wb_data[gi] = wb_pkt[gi].wb_data[XLEN-1:0];
    assign wb_we[gi]   = wb_pkt[gi].wb_enable && wb_pkt[gi].valid_opcode && (wb_addr[gi] != '0);
  end

  always_comb begin
    clr_mask     = '0;
    commit_count = '0;
    for (int p = 0; p < NWB; p++) begin
      if (wb_we[p]) clr_mask[wb_addr[p]] = 1'b1;
      if (wb_pkt[p].wb_enable) commit_count = commit_count + CW'(1);
    end
  end

  assign rs1     = in_pkt.rs1_sel[AW-1:0];
  assign rs2     = in_pkt.rs2_sel[AW-1:0];
  assign rd      = in_pkt.rd_sel[AW-1:0];
  assign out_rd  = out_pkt.rd_sel[AW-1:0];
  assign rd_addr = {rs2, rs1};

  // A producer retiring this cycle no longer blocks its consumers.
  assign busy_eff = busy & ~clr_mask;
  assign hazard   = busy_eff[rs1] || busy_eff[rs2] || (in_pkt.rd_wen && busy_eff[rd]);
  assign in_ready = !hazard && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_comb begin
    set_mask   = '0;
    flush_mask = '0;
    if (accept && in_pkt.rd_wen && in_pkt.valid_opcode && rd != '0) set_mask[rd] = 1'b1;
    if (flush && out_valid && out_pkt.rd_wen && out_pkt.valid_opcode) flush_mask[out_rd] = 1'b1;
  end

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NWB(NWB)) u_rf (
    .clk     (clk),
    .resetn  (resetn),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_comb begin
    issue_next              = '0;
    issue_next.rs1_value    = PKT_XLEN'(rd_data[0]);
    issue_next.rs2_value    = PKT_XLEN'(rd_data[1]);
    issue_next.rs1_sel      = in_pkt.rs1_sel;
    issue_next.rs2_sel      = in_pkt.rs2_sel;
    issue_next.rd_sel       = in_pkt.rd_sel;
    issue_next.rd_wen       = in_pkt.rd_wen;
    issue_next.imm32        = in_pkt.imm32;
    issue_next.alu_op       = in_pkt.alu_op;
    issue_next.pc           = in_pkt.pc;
    issue_next.valid_opcode = in_pkt.valid_opcode;
    issue_next.dont_forward = in_pkt.dont_forward;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      busy         <= '0;
      out_valid    <= 1'b0;
      out_pkt      <= '0;
      stall_cycles <= '0;
    end else begin
      // A new producer setting a bit overrides a same-cycle clear.
      busy <= (busy & ~clr_mask & ~flush_mask) | set_mask;
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_pkt   <= issue_next;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (in_valid && hazard && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
    end
  end
endmodule

// File: tb/tb_regfile_issue_stage.sv
// Randomized and directed scoreboard bench for regfile_issue_stage.
module tb_regfile_issue_stage;
  import rv32_pkg::*;
  localparam int NWB = 2;

  logic                clk = 1'b0;
  logic                resetn = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  rv32_instr_packet_t  in_pkt = '0;
  rv32_mem2wb_packet_t wb_pkt [NWB];
  logic                out_valid;
  logic                out_ready = 1'b1;
  rv32_issue_packet_t  out_pkt;
  logic                flush = 1'b0;
  logic [1:0]          commit_count;
  logic [31:0]         stall_cycles;

  regfile_issue_stage #(.XLEN(32), .NREGS(32), .NWB(NWB)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pkt       (in_pkt),
    .wb_pkt       (wb_pkt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pkt      (out_pkt),
    .flush        (flush),
    .commit_count (commit_count),
    .stall_cycles (stall_cycles)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0]        mregs [32];
  bit                 mbusy [32];
  bit                 mvalid;
  int unsigned        mstall;
  rv32_issue_packet_t expq [$];

  // Next-cycle stimulus
  bit                  n_in_valid, n_out_ready, n_flush;
  rv32_instr_packet_t  n_pkt;
  rv32_mem2wb_packet_t n_wb [NWB];

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = '0;
      mbusy[r] = 0;
    end
    mvalid = 0;
    mstall = 0;
    expq.delete();
  endtask

  task automatic set_idle();
    n_in_valid  = 0;
    n_out_ready = 1;
    n_flush     = 0;
    n_pkt       = '0;
    for (int p = 0; p < NWB; p++) n_wb[p] = '0;
  endtask

  function automatic rv32_instr_packet_t mk(input int rs1, input int rs2, input int rd, input bit wen);
    rv32_instr_packet_t k;
    k              = '0;
    k.rs1_sel      = 5'(rs1);
    k.rs2_sel      = 5'(rs2);
    k.rd_sel       = 5'(rd);
    k.rd_wen       = wen;
    k.imm32        = $urandom;
    k.alu_op       = 4'($urandom_range(0, 15));
    k.pc           = $urandom;
    k.valid_opcode = 1'b1;
    return k;
  endfunction

  function automatic rv32_mem2wb_packet_t mkwb(input int addr, input logic [31:0] data);
    rv32_mem2wb_packet_t w;
    w.wb_enable    = 1'b1;
    w.valid_opcode = 1'b1;
    w.wb_addr      = 5'(addr);
    w.wb_data      = data;
    return w;
  endfunction

  // Drive one cycle of stimulus, check the combinational view, then advance the model.
  task automatic cycle();
    logic [31:0]        nregs [32];
    bit                 clr [32];
    bit                 haz, rdy, acc;
    int                 cc, a;
    rv32_issue_packet_t e, f;
    @(negedge clk);
    #2;
    in_valid  = n_in_valid;
    in_pkt    = n_pkt;
    out_ready = n_out_ready;
    flush     = n_flush;
    for (int p = 0; p < NWB; p++) wb_pkt[p] = n_wb[p];
    #2;
    cc = 0;
    for (int r = 0; r < 32; r++) begin
      nregs[r] = mregs[r];
      clr[r]   = 0;
    end
    for (int p = 0; p < NWB; p++) begin
      if (n_wb[p].wb_enable) cc++;
      a = int'(n_wb[p].wb_addr);
      if (n_wb[p].wb_enable && n_wb[p].valid_opcode && a != 0) begin
        nregs[a] = n_wb[p].wb_data;
        clr[a]   = 1;
      end
    end
    haz = (mbusy[n_pkt.rs1_sel] && !clr[n_pkt.rs1_sel]) ||
          (mbusy[n_pkt.rs2_sel] && !clr[n_pkt.rs2_sel]) ||
          (n_pkt.rd_wen && mbusy[n_pkt.rd_sel] && !clr[n_pkt.rd_sel]);
    rdy = !haz && (!mvalid || n_out_ready) && !n_flush;
    chk("in_ready", 160'(in_ready), 160'(rdy));
    chk("out_valid", 160'(out_valid), 160'(mvalid));
    chk("commit_count", 160'(commit_count), 160'(cc));
    chk("stall_cycles", 160'(stall_cycles), 160'(mstall));
    acc = n_in_valid && rdy;
    if (n_flush && mvalid && expq.size() > 0) begin
      f = expq.pop_back();
      if (f.rd_wen && f.valid_opcode && f.rd_sel != 0) mbusy[f.rd_sel] = 0;
    end
    for (int r = 0; r < 32; r++) if (clr[r]) mbusy[r] = 0;
    if (acc) begin
      e              = '0;
      e.rs1_value    = (n_pkt.rs1_sel == 0) ? 32'd0 : nregs[n_pkt.rs1_sel];
      e.rs2_value    = (n_pkt.rs2_sel == 0) ? 32'd0 : nregs[n_pkt.rs2_sel];
      e.rs1_sel      = n_pkt.rs1_sel;
      e.rs2_sel      = n_pkt.rs2_sel;
      e.rd_sel       = n_pkt.rd_sel;
      e.rd_wen       = n_pkt.rd_wen;
      e.imm32        = n_pkt.imm32;
      e.alu_op       = n_pkt.alu_op;
      e.pc           = n_pkt.pc;
      e.valid_opcode = n_pkt.valid_opcode;
      e.dont_forward = n_pkt.dont_forward;
      expq.push_back(e);
      if (n_pkt.rd_wen && n_pkt.valid_opcode && n_pkt.rd_sel != 0) mbusy[n_pkt.rd_sel] = 1;
    end
    if (n_flush)          mvalid = 0;
    else if (acc)         mvalid = 1;
    else if (n_out_ready) mvalid = 0;
    if (n_in_valid && haz && mstall != 32'hFFFF_FFFF) mstall++;
    for (int r = 0; r < 32; r++) mregs[r] = nregs[r];
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    in_valid  = 0;
    flush     = 0;
    out_ready = 1;
    for (int p = 0; p < NWB; p++) wb_pkt[p] = '0;
    resetn = 0;
    model_reset();
    #2;
    chk("rst_out_valid", 160'(out_valid), 160'(0));
    chk("rst_out_pkt", 160'(out_pkt), 160'(0));
    chk("rst_stall", 160'(stall_cycles), 160'(0));
    @(negedge clk);
    #1;
    resetn = 1;
  endtask

  task automatic rand_cycle();
    n_in_valid = ($urandom_range(0, 3) != 0);
    n_pkt      = mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), 1'($urandom_range(0, 1)));
    n_pkt.valid_opcode = ($urandom_range(0, 7) != 0);
    n_pkt.dont_forward = 1'($urandom_range(0, 1));
    for (int p = 0; p < NWB; p++) begin
      n_wb[p] = mkwb($urandom_range(0, 7), $urandom);
      n_wb[p].wb_enable    = ($urandom_range(0, 2) == 0);
      n_wb[p].valid_opcode = ($urandom_range(0, 5) != 0);
    end
    n_out_ready = ($urandom_range(0, 3) != 0);
    n_flush     = !n_out_ready && ($urandom_range(0, 15) == 0);
    cycle();
  endtask

  // Monitor: pops the expected packet on every downstream handshake.
  initial begin
    rv32_issue_packet_t e;
    forever begin
      @(negedge clk);
      #3;
      if (resetn && out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("unexpected_issue", 160'(out_pkt), 160'(0) + 160'(1) + 160'(out_pkt));
        end else begin
          e = expq.pop_front();
          chk("issue_pkt", 160'(out_pkt), 160'(e));
        end
      end
    end
  end

  initial begin
    for (int p = 0; p < NWB; p++) wb_pkt[p] = '0;
    model_reset();
    set_idle();
    #12;
    chk("reset_out_valid", 160'(out_valid), 160'(0));
    chk("reset_out_pkt", 160'(out_pkt), 160'(0));
    chk("reset_stall", 160'(stall_cycles), 160'(0));
    chk("reset_in_ready", 160'(in_ready), 160'(1));
    @(negedge clk);
    #1;
    resetn = 1;

    // Same-cycle writeback bypass into the issued operand
    set_idle();
    n_wb[0] = mkwb(5, 32'hDEADBEEF);
    n_in_valid = 1; n_pkt = mk(5, 0, 0, 0);
    cycle();
    @(posedge clk); #1;
    chk("x5_bypass", 160'(out_pkt.rs1_value), 160'(32'hDEADBEEF));

    // Two ports writing the same register: port 1 wins
    set_idle();
    n_wb[0] = mkwb(7, 32'h11);
    n_wb[1] = mkwb(7, 32'h22);
    cycle();
    set_idle();
    n_in_valid = 1; n_pkt = mk(7, 5, 0, 0);
    cycle();
    @(posedge clk); #1;
    chk("x7_priority", 160'(out_pkt.rs1_value), 160'(32'h22));

    // RAW hazard stalls until the producer writes back
    set_idle();
    n_in_valid = 1; n_pkt = mk(0, 0, 3, 1);
    cycle();
    set_idle();
    n_in_valid = 1; n_pkt = mk(3, 0, 0, 0);
    cycle();
    cycle();
    n_wb[0] = mkwb(3, 32'h55);
    cycle();
    @(posedge clk); #1;
    chk("x3_release", 160'(out_pkt.rs1_value), 160'(32'h55));
    chk("x3_stalls", 160'(stall_cycles), 160'(2));

    // Back-pressure holds the issue register
    set_idle();
    n_in_valid = 1; n_pkt = mk(1, 2, 0, 0);
    cycle();
    n_out_ready = 0; n_pkt = mk(2, 1, 0, 0);
    cycle(); cycle(); cycle();
    n_out_ready = 1;
    cycle();

    // Register 0 ignores writes and never stalls
    set_idle();
    n_wb[1] = mkwb(0, 32'hFFFF);
    cycle();
    n_wb[1] = '0;
    n_in_valid = 1; n_pkt = mk(0, 0, 0, 1);
    cycle();
    n_pkt = mk(0, 0, 0, 0);
    cycle();
    @(posedge clk); #1;
    chk("x0_read", 160'(out_pkt.rs1_value), 160'(0));

    // Flush releases the flushed instruction's destination
    set_idle();
    n_in_valid = 1; n_pkt = mk(0, 0, 9, 1);
    cycle();
    set_idle();
    n_out_ready = 0; n_flush = 1;
    cycle();
    set_idle();
    n_in_valid = 1; n_pkt = mk(9, 0, 0, 0);
    cycle();

    for (int i = 0; i < 2000; i++) rand_cycle();
    mid_reset();
    for (int i = 0; i < 1000; i++) rand_cycle();

    set_idle();
    for (int i = 0; i < 4; i++) cycle();
    chk("queue_drained", 160'(expq.size()), 160'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
